// File: rtl/ddr3_wrlvl_pkg.sv
// Shared types and defaults for the DDR3 DQSW write-leveling controller.
// WRLVL_SAMPLE_FILTER_EN selects the multi-sample feedback filter.
package ddr3_wrlvl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_MOVE,
        ST_DONE,
        ST_FAIL
    } wrlvl_state_t;

    localparam int DEF_TAP_W         = 7;
    localparam int DEF_MAX_TAPS      = 128;
    localparam int DEF_SETTLE_CYCLES = 8;
    localparam int DEF_SAMPLE_COUNT  = 4;

`ifdef WRLVL_SAMPLE_FILTER_EN
    localparam bit SAMPLE_FILTER_EN = 1'b1;
`else
    localparam bit SAMPLE_FILTER_EN = 1'b0;
`endif

    // Without the filter every tap is judged on a single feedback sample.
    function automatic int sample_cycles(input int sample_count);
        return SAMPLE_FILTER_EN ? sample_count : 1;
    endfunction

endpackage

// File: rtl/ddr3_wrlvl_sample_filter.sv
// Collects SAMPLE_CYCLES consecutive RX_DATA samples; level is 1 only if all were 2'b11.
// Sample count is chosen by the controller (WRLVL_SAMPLE_FILTER_EN).
module ddr3_wrlvl_sample_filter #(
    parameter int SAMPLE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       sample_en_i,
    input  logic [1:0] rx_data_i,
    output logic       level_o,
    output logic       valid_o
);

    localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             all_ones_q, all_ones_d;
    logic             hit;
    logic             last;

    always_comb begin
        hit        = (rx_data_i == 2'b11);
        last       = (cnt_q == CNT_W'(SAMPLE_CYCLES - 1));
        cnt_d      = cnt_q;
        all_ones_d = all_ones_q;
        valid_o    = 1'b0;
        level_o    = all_ones_q & hit;
        if (sample_en_i) begin
            if (last) begin
                valid_o    = 1'b1;
                cnt_d      = '0;
                all_ones_d = 1'b1;
            end else begin
                cnt_d      = cnt_q + 1'b1;
                all_ones_d = all_ones_q & hit;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q      <= '0;
            all_ones_q <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            all_ones_q <= all_ones_d;
        end
    end

endmodule

// File: rtl/ddr3_dqsw_wrlvl_ctrl.sv
// Write-leveling controller for one DDR3 DQSW lane: sweeps IOD delay taps until CK feedback
// goes 0->1 and reports the tap. WRLVL_SAMPLE_FILTER_EN enables multi-sample filtering.
//
// state  | meaning
// IDLE   | waiting for START
// LOAD   | reload IOD delay line to tap 0, clear eye-monitor flags
// SETTLE | wait SETTLE_CYCLES for the delay line to settle
// SAMPLE | collect feedback samples for the current tap
// EVAL   | judge the tap level, decide DONE / FAIL / MOVE
// MOVE   | step the delay line up one tap
// DONE   | 0->1 edge found, TAP_VALUE holds the tap
// FAIL   | sweep exhausted or delay line out of range
module ddr3_dqsw_wrlvl_ctrl
    import ddr3_wrlvl_pkg::*;
#(
    parameter int TAP_W         = DEF_TAP_W,
    parameter int MAX_TAPS      = DEF_MAX_TAPS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SAMPLE_COUNT  = DEF_SAMPLE_COUNT
) (
    input  logic             fab_clk_i,
    input  logic             arst_n_i,
    input  logic             start_i,
    input  logic [1:0]       rx_data_i,
    input  logic             delay_line_out_of_range_i,
    output logic             delay_line_move_o,
    output logic             delay_line_direction_o,
    output logic             delay_line_load_o,
    output logic             eye_monitor_clear_flags_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             fail_o,
    output logic [TAP_W-1:0] tap_value_o
);

    localparam int SAMPLE_CYCLES = sample_cycles(SAMPLE_COUNT);
    localparam int SET_W         = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(MAX_TAPS - 1);

    logic [1:0]       rst_sync_q;
    logic             rst_n;
    wrlvl_state_t     state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             seen_zero_q, seen_zero_d;
    logic             level_q, level_d;
    logic             flt_level, flt_valid;
    logic             in_sweep;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge fab_clk_i or negedge arst_n_i) begin
        if (!arst_n_i) rst_sync_q <= '0;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    ddr3_wrlvl_sample_filter #(
        .SAMPLE_CYCLES(SAMPLE_CYCLES)
    ) u_filter (
        .clk_i      (fab_clk_i),
        .rst_n_i    (rst_n),
        .sample_en_i(state_q == ST_SAMPLE),
        .rx_data_i  (rx_data_i),
        .level_o    (flt_level),
        .valid_o    (flt_valid)
    );

    always_ff @(posedge fab_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tap_q       <= '0;
            settle_q    <= '0;
            seen_zero_q <= 1'b0;
            level_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            settle_q    <= settle_d;
            seen_zero_q <= seen_zero_d;
            level_q     <= level_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        settle_d    = settle_q;
        seen_zero_d = seen_zero_q;
        level_d     = level_q;
        in_sweep    = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE) ||
                      (state_q == ST_EVAL)   || (state_q == ST_MOVE);
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start_i) begin
                    state_d     = ST_LOAD;
                    tap_d       = '0;
                    seen_zero_d = 1'b0;
                end
            end
            ST_LOAD: begin
                state_d  = ST_SETTLE;
                settle_d = SETTLE_INIT;
            end
            ST_SETTLE: begin
                if (settle_q == '0) state_d = ST_SAMPLE;
                else                settle_d = settle_q - 1'b1;
            end
            ST_SAMPLE: begin
                if (flt_valid) begin
                    state_d = ST_EVAL;
                    level_d = flt_level;
                end
            end
            ST_EVAL: begin
                // A 1 before any 0 means DQS is already past the CK edge: keep sweeping.
                if (level_q && seen_zero_q) begin
                    state_d = ST_DONE;
                end else begin
                    if (!level_q) seen_zero_d = 1'b1;
                    state_d = (tap_q == LAST_TAP) ? ST_FAIL : ST_MOVE;
                end
            end
            ST_MOVE: begin
                tap_d    = tap_q + 1'b1;
                state_d  = ST_SETTLE;
                settle_d = SETTLE_INIT;
            end
            default: state_d = ST_IDLE;
        endcase
        if (in_sweep && delay_line_out_of_range_i) state_d = ST_FAIL;
    end

    assign delay_line_move_o         = (state_q == ST_MOVE);
    assign delay_line_direction_o    = (state_q == ST_MOVE);
    assign delay_line_load_o         = (state_q == ST_LOAD);
    assign eye_monitor_clear_flags_o = (state_q == ST_LOAD);
    assign busy_o                    = in_sweep || (state_q == ST_LOAD);
    assign done_o                    = (state_q == ST_DONE);
    assign fail_o                    = (state_q == ST_FAIL);
    assign tap_value_o               = tap_q;

endmodule

// File: tb/tb_ddr3_dqsw_wrlvl_ctrl.sv
// Self-checking bench for ddr3_dqsw_wrlvl_ctrl: IOD delay-line model drives feedback,
// a table of sweep scenarios feeds an expected-result queue checked at DONE/FAIL.
module tb_ddr3_dqsw_wrlvl_ctrl;

    localparam int SETTLE = 8;
`ifdef WRLVL_SAMPLE_FILTER_EN
    localparam int SC   = 4;
    localparam bit FILT = 1'b1;
`else
    localparam int SC   = 1;
    localparam bit FILT = 1'b0;
`endif
    localparam int P      = SETTLE + SC + 2;
    localparam int BUDGET = 4000;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       start = 1'b0;
    logic       oor = 1'b0;
    logic [1:0] rx = 2'b00;
    logic       move, dir, load, clr, busy, done, fail;
    logic [6:0] tap;

    ddr3_dqsw_wrlvl_ctrl dut (
        .fab_clk_i                (clk),
        .arst_n_i                 (arst_n),
        .start_i                  (start),
        .rx_data_i                (rx),
        .delay_line_out_of_range_i(oor),
        .delay_line_move_o        (move),
        .delay_line_direction_o   (dir),
        .delay_line_load_o        (load),
        .eye_monitor_clear_flags_o(clr),
        .busy_o                   (busy),
        .done_o                   (done),
        .fail_o                   (fail),
        .tap_value_o              (tap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;
        int a;
        int b;
        int oor_tap;
        bit mid_start;
        bit exp_done;
        int exp_tap;
        int exp_moves;
        int exp_cyc;
    } vec_t;

    vec_t vecs[7];
    vec_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc, iod_tap, since;
    int n_move, n_load, n_clr, load_cyc, dir_bad, clr_bad, busy_bad;
    int cur_mode, cur_a, cur_b, cur_oor;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(input int mode, input int a, input int b, input int oor_tap,
                                input bit mid, input bit d, input int t, input int mv,
                                input int cy);
        vec_t v;
        v.mode = mode; v.a = a; v.b = b; v.oor_tap = oor_tap; v.mid_start = mid;
        v.exp_done = d; v.exp_tap = t; v.exp_moves = mv; v.exp_cyc = cy;
        return v;
    endfunction

    // Cycle at which DONE/FAIL appears after judging tap n (tap n step pulse at 1+P*n).
    function automatic int fin(input int n);
        return 1 + P * n + P;
    endfunction

    // Feedback seen by the lane for IOD tap t, s cycles after the last LOAD/MOVE.
    function automatic logic [1:0] fb(input int t, input int s);
        case (cur_mode)
            0: return (t >= cur_a) ? 2'b11 : 2'b00;
            1: return (t < cur_a || t >= cur_b) ? 2'b11 : 2'b00;
            4: return (t == cur_a && s == SETTLE + 3) ? 2'b01 : 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
        if (load) begin
            iod_tap  = 0;
            since    = 0;
            n_load++;
            load_cyc = cyc;
        end else if (move) begin
            if (dir) iod_tap++;
            since = 0;
            n_move++;
        end else begin
            since++;
        end
        if (clr) n_clr++;
        if (clr != load) clr_bad++;
        if (dir != move) dir_bad++;
        rx  = fb(iod_tap, since);
        oor = (cur_mode == 3 && iod_tap == cur_oor && since == 3);
    endtask

    task automatic run_case(input vec_t v, input int idx);
        vec_t e;
        int   mv_hold;
        string tag;
        tag = $sformatf("case%0d", idx);
        cur_mode = v.mode; cur_a = v.a; cur_b = v.b; cur_oor = v.oor_tap;
        exp_q.push_back(v);
        n_move = 0; n_load = 0; n_clr = 0; load_cyc = -1;
        dir_bad = 0; clr_bad = 0; busy_bad = 0;
        start = 1'b1;
        cyc   = 0;
        step();
        while (!(done || fail) && cyc < BUDGET) begin
            if (!busy) busy_bad++;
            start = (v.mid_start && cyc == 50);
            step();
        end
        start = 1'b0;
        if (!(done || fail)) check({tag, " timeout"}, 0, 1);
        e = exp_q.pop_front();
        check({tag, " done"},      int'(done),   int'(e.exp_done));
        check({tag, " fail"},      int'(fail),   int'(!e.exp_done));
        check({tag, " tap"},       int'(tap),    e.exp_tap);
        check({tag, " cycle"},     cyc,          e.exp_cyc);
        check({tag, " moves"},     n_move,       e.exp_moves);
        check({tag, " loads"},     n_load,       1);
        check({tag, " clears"},    n_clr,        1);
        check({tag, " load_cyc"},  load_cyc,     1);
        check({tag, " dir_bad"},   dir_bad,      0);
        check({tag, " clr_bad"},   clr_bad,      0);
        check({tag, " busy_run"},  busy_bad,     0);
        check({tag, " busy_end"},  int'(busy),   0);
        mv_hold = n_move;
        repeat (20) step();
        check({tag, " hold_moves"}, n_move, mv_hold);
        check({tag, " hold_state"}, int'({done, fail}), e.exp_done ? 2 : 1);
        check({tag, " hold_tap"},   int'(tap), e.exp_tap);
    endtask

    initial begin
        vecs[0] = mk(0, 20, 0, 0, 1'b1, 1'b1, 20, 20, fin(20));
        vecs[1] = mk(1, 5, 10, 0, 1'b0, 1'b1, 10, 10, fin(10));
        vecs[2] = mk(2, 0, 0, 0, 1'b0, 1'b0, 127, 127, fin(127));
        vecs[3] = mk(3, 0, 0, 7, 1'b0, 1'b0, 7, 7, 1 + P * 7 + 4);
        if (FILT) vecs[4] = mk(4, 12, 0, 0, 1'b0, 1'b1, 13, 13, fin(13));
        else      vecs[4] = mk(4, 12, 0, 0, 1'b0, 1'b0, 127, 127, fin(127));
        vecs[5] = mk(0, 0, 0, 0, 1'b0, 1'b0, 127, 127, fin(127));
        vecs[6] = mk(0, 1, 0, 0, 1'b0, 1'b1, 1, 1, fin(1));

        cur_mode = 2; iod_tap = 0; since = 0; cyc = 0;
        n_move = 0; n_load = 0; n_clr = 0; clr_bad = 0; dir_bad = 0;

        // Reset held, then released: everything quiet.
        repeat (3) step();
        check("reset_outputs", int'({move, dir, load, clr, busy, done, fail, tap}), 0);
        arst_n = 1'b1;
        n_move = 0; n_load = 0; n_clr = 0;
        repeat (6) step();
        check("post_reset_pulses", n_move + n_load + n_clr, 0);
        check("post_reset_outputs", int'({move, dir, load, clr, busy, done, fail, tap}), 0);

        for (int i = 0; i < 7; i++) run_case(vecs[i], i);

        // Async reset mid-sweep, then restart from scratch.
        cur_mode = 0; cur_a = 30;
        start = 1'b1; cyc = 0;
        step();
        start = 1'b0;
        repeat (40) step();
        check("mid_sweep_busy", int'(busy), 1);
        #1 arst_n = 1'b0;
        #1 check("arst_immediate", int'({move, dir, load, clr, busy, done, fail, tap}), 0);
        repeat (3) step();
        arst_n = 1'b1;
        repeat (4) step();
        check("arst_released", int'({move, dir, load, clr, busy, done, fail, tap}), 0);
        run_case(vecs[6], 7);

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
